imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Write-side companion to the instruction-fetch byte memory: accepts 32-bit instruction words
//  over a valid/ready stream and serialises each into four byte writes, little-endian, so the
//  fetch read {m[a+3],m[a+2],m[a+1],m[a]} returns the original word. Sits between the program
//  source (bench/boot UART) and the byte-array write port of the text memory.
// PARAMETERS
//  DEPTH  8    bits per memory entry (one byte)
//  WIDTH  128  number of byte entries in text memory; power of two
// PORTS
//  clk          in   1                 rising-edge clock
//  rst          in   1                 asynchronous, active-high reset
//  start        in   1                 begin a load session at base_addr (sampled in IDLE only)
//  base_addr    in   $clog2(WIDTH)     first byte address of the session
//  word_valid   in   1                 word_data/word_last valid
//  word_data    in   4*DEPTH           instruction word; bits [DEPTH-1:0] = lowest address byte
//  word_last    in   1                 final word of session
//  word_ready   out  1                 loader can accept a word this cycle
//  mem_we       out  1                 byte write strobe to text memory
//  mem_waddr    out  $clog2(WIDTH)     byte write address
//  mem_wdata    out  DEPTH             byte write data
//  busy         out  1                 session in progress (state != IDLE)
//  done         out  1                 one-cycle pulse after last byte of session written
//  wrapped      out  1                 sticky: a write address wrapped past WIDTH-1 this session
//  words_loaded out  $clog2(WIDTH)+1   words fully written this session
// BEHAVIOUR
//  - Reset (async): state=IDLE, all outputs 0, address/byte index/counters 0, word register 0.
//  - All outputs are driven from registers; no combinational path from inputs to outputs.
//  - States: IDLE -> (start) ACCEPT -> (valid&ready) WRITE x4 beats -> ACCEPT, or DONE if the
//    accepted word had word_last=1 -> IDLE after one cycle.
//  - IDLE: start=1 latches base_addr into addr, clears words_loaded and wrapped; next state ACCEPT.
//  - ACCEPT: word_ready=1. Handshake on valid&ready at the clock edge: word_data and word_last
//    latched, next state WRITE with byte index 0. word_valid without ready is held by source.
//  - WRITE: word_ready=0, mem_we=1 for exactly 4 consecutive cycles; beat k (0..3) drives
//    mem_wdata=word[k*DEPTH +: DEPTH], mem_waddr=addr; addr increments by 1 after each beat.
//    After beat 3 words_loaded increments (same edge as leaving WRITE).
//  - Throughput: one word per 5 cycles (1 accept + 4 writes). Latency handshake->first mem_we: 1 cycle.
//  - DONE: mem_we=0, done=1 for one cycle, busy=1; next IDLE (busy=0, done=0).
//  - Wrap-around: addr is modulo WIDTH; increment from WIDTH-1 gives 0 and sets wrapped (sticky
//    until next start). Writing continues; no error stall.
//  - start while busy: ignored. start and word_valid in the same IDLE cycle: only start acts;
//    word accepted no earlier than the following cycle.
//  - word_last on the first word: session of exactly one word, done 5 cycles after handshake.
//  - words_loaded saturates at 2^($clog2(WIDTH)+1)-1, never rolls over.
//  - Reset mid-WRITE: writes stop immediately (mem_we=0 asynchronously); partial word is not
//    completed; memory contents already written are untouched.
// STRUCTURE
//  - Shared package/header: state encodings (IDLE, ACCEPT, WRITE, DONE) as localparams and
//    BYTES_PER_WORD=4, shared with the fetch-side memory so both agree on byte order.
//  - Single module; the 2-bit byte index and word register form a natural sub-module
//    imem_word_serializer if reused, but are kept inline here.
// TESTING
//  - Reset: assert rst mid-cycle -> all outputs 0 immediately; busy=0, word_ready=0.
//  - Single word: start, base=0x10; word 0x00A00093 last=1 -> writes 0x93@0x10,0x00@0x11,
//    0xA0@0x12,0x00@0x13 on 4 consecutive cycles; done pulses next cycle; words_loaded=1.
//  - Back-pressure: hold word_valid=1 with 3 words -> word_ready=1 only every 5th cycle; bytes
//    land at base..base+11 in order; fetch-side read at base+4 returns word 2 exactly.
//  - Wrap: base=0x7E, one word 0x11223344 -> 0x44@0x7E,0x33@0x7F,0x22@0x00,0x11@0x01; wrapped=1.
//  - Ignored events: start pulsed during WRITE -> no address reload, session unaffected; start
//    with word_valid in IDLE -> word accepted on the following cycle, not the same one.
//  - Reset mid-WRITE after beat 1 -> only beats 0-1 written; next session starts cleanly.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// ---------------------------------------------------------------------------
// imem_loader_pkg
//   Shared definitions for the instruction-memory loader and the fetch-side
//   byte memory. Both sides must agree on the number of bytes per word and
//   on the byte order: byte k of a word lives at address base + k
//   (little-endian).
// ---------------------------------------------------------------------------
package imem_loader_pkg;

    localparam int BYTES_PER_WORD = 4;

    // Loader FSM encodings
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_WRITE  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Index of the final byte beat of a word
    localparam logic [1:0] BEAT_LAST = 2'(BYTES_PER_WORD - 1);

endpackage

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//   Accepts 32-bit instruction words on a valid/ready stream and writes each
//   one into the byte-wide text memory as four consecutive byte writes,
//   lowest byte first, so a fetch of {m[a+3],m[a+2],m[a+1],m[a]} returns
//   the original word.
//
// Parameters
//   DEPTH  bits per memory entry (one byte)
//   WIDTH  number of byte entries in the text memory (power of two)
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   start, base_addr    open a session at base_addr (only honoured in IDLE)
//   word_valid/_data/_last/_ready   instruction word stream
//   mem_we/_waddr/_wdata            byte write port of the text memory
//   busy                session in progress
//   done                one-cycle pulse once the last byte is written
//   wrapped             sticky: the write address rolled past WIDTH-1
//   words_loaded        words fully written this session (saturating)
//
// Every output is a flop; nothing combinational reaches an output.
// ---------------------------------------------------------------------------
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 128
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [$clog2(WIDTH)-1:0]   base_addr,
    input  logic                       word_valid,
    input  logic [4*DEPTH-1:0]         word_data,
    input  logic                       word_last,
    output logic                       word_ready,
    output logic                       mem_we,
    output logic [$clog2(WIDTH)-1:0]   mem_waddr,
    output logic [DEPTH-1:0]           mem_wdata,
    output logic                       busy,
    output logic                       done,
    output logic                       wrapped,
    output logic [$clog2(WIDTH):0]     words_loaded
);

    localparam int AW = $clog2(WIDTH);
    localparam int CW = AW + 1;

    state_t                r_state;
    logic [AW-1:0]         r_addr;
    logic [1:0]            r_idx;
    logic [4*DEPTH-1:0]    r_word;
    logic                  r_last;
    logic                  r_ready;
    logic                  r_we;
    logic [AW-1:0]         r_waddr;
    logic [DEPTH-1:0]      r_wdata;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_wrapped;
    logic [CW-1:0]         r_words;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_addr    <= '0;
            r_idx     <= '0;
            r_word    <= '0;
            r_last    <= 1'b0;
            r_ready   <= 1'b0;
            r_we      <= 1'b0;
            r_waddr   <= '0;
            r_wdata   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_wrapped <= 1'b0;
            r_words   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // word_valid is deliberately ignored here: a word can only
                    // be taken once ready has been presented in ACCEPT.
                    if (start) begin
                        r_addr    <= base_addr;
                        r_words   <= '0;
                        r_wrapped <= 1'b0;
                        r_busy    <= 1'b1;
                        r_ready   <= 1'b1;
                        r_state   <= ST_ACCEPT;
                    end
                end

                ST_ACCEPT: begin
                    if (word_valid && r_ready) begin
                        // Beat 0 goes out on the very next cycle, so load
                        // the write port straight from the input word.
                        r_word  <= word_data;
                        r_last  <= word_last;
                        r_idx   <= '0;
                        r_ready <= 1'b0;
                        r_we    <= 1'b1;
                        r_waddr <= r_addr;
                        r_wdata <= word_data[DEPTH-1:0];
                        r_state <= ST_WRITE;
                    end
                end

                ST_WRITE: begin
                    r_addr <= r_addr + AW'(1);
                    if (r_addr == '1)
                        r_wrapped <= 1'b1;
                    if (r_idx == BEAT_LAST) begin
                        r_we <= 1'b0;
                        if (r_words != '1)
                            r_words <= r_words + CW'(1);
                        if (r_last) begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_ready <= 1'b1;
                            r_state <= ST_ACCEPT;
                        end
                    end else begin
                        // Word register shifts down one byte per beat so the
                        // next byte is always sitting in its second slot.
                        r_idx   <= r_idx + 2'd1;
                        r_word  <= r_word >> DEPTH;
                        r_waddr <= r_addr + AW'(1);
                        r_wdata <= r_word[2*DEPTH-1 -: DEPTH];
                    end
                end

                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign word_ready   = r_ready;
    assign mem_we       = r_we;
    assign mem_waddr    = r_waddr;
    assign mem_wdata    = r_wdata;
    assign busy         = r_busy;
    assign done         = r_done;
    assign wrapped      = r_wrapped;
    assign words_loaded = r_words;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    localparam int DEPTH = 8;
    localparam int WIDTH = 128;
    localparam int AW    = $clog2(WIDTH);

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [AW-1:0]     base_addr;
    logic              word_valid;
    logic [31:0]       word_data;
    logic              word_last;
    logic              word_ready;
    logic              mem_we;
    logic [AW-1:0]     mem_waddr;
    logic [7:0]        mem_wdata;
    logic              busy;
    logic              done;
    logic              wrapped;
    logic [AW:0]       words_loaded;

    imem_loader #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .word_valid(word_valid), .word_data(word_data), .word_last(word_last),
        .word_ready(word_ready), .mem_we(mem_we), .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata), .busy(busy), .done(done), .wrapped(wrapped),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    logic [7:0] mem [WIDTH];

    always @(posedge clk) cyc <= cyc + 1;

    // text memory model: each write beat lasts exactly one cycle
    always @(negedge clk) if (mem_we) mem[mem_waddr] = mem_wdata;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] fetch(input int a);
        return {mem[(a+3)%WIDTH], mem[(a+2)%WIDTH], mem[(a+1)%WIDTH], mem[a%WIDTH]};
    endfunction

    task automatic do_start(input logic [AW-1:0] b);
        start = 1'b1; base_addr = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!word_ready && n < 20) begin @(negedge clk); n++; end
        if (!word_ready) chk(tag, 32'(word_ready), 32'd1);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 20) begin @(negedge clk); n++; end
        chk(tag, 32'(done), 32'd1);
    endtask

    task automatic send_word(input logic [31:0] d, input logic l, input string tag);
        word_valid = 1'b1; word_data = d; word_last = l;
        wait_ready(tag);
        @(negedge clk);   // handshake happened on the intervening edge
    endtask

    logic [31:0] bp_w [3];
    int          rc   [3];
    logic [7:0]  exp_b[4];

    initial begin
        for (int i = 0; i < WIDTH; i++) mem[i] = 8'hEE;
        rst = 1'b1; start = 1'b0; base_addr = '0;
        word_valid = 1'b0; word_data = '0; word_last = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(word_ready), 0);
        chk("rst_we",    32'(mem_we), 0);
        chk("rst_busy",  32'(busy), 0);
        chk("rst_done",  32'(done), 0);
        chk("rst_words", 32'(words_loaded), 0);
        rst = 1'b0;
        @(negedge clk);

        // single word, start and word_valid together in IDLE
        start = 1'b1; base_addr = 7'h10;
        word_valid = 1'b1; word_data = 32'h00A00093; word_last = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("sw_acc_ready", 32'(word_ready), 1);
        chk("sw_no_same_cycle_we", 32'(mem_we), 0);
        chk("sw_busy", 32'(busy), 1);
        @(negedge clk);
        word_valid = 1'b0;
        exp_b = '{8'h93, 8'h00, 8'hA0, 8'h00};
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("sw_we%0d", k),    32'(mem_we), 1);
            chk($sformatf("sw_addr%0d", k),  32'(mem_waddr), 32'h10 + k);
            chk($sformatf("sw_data%0d", k),  32'(mem_wdata), 32'(exp_b[k]));
            chk($sformatf("sw_rdy%0d", k),   32'(word_ready), 0);
            @(negedge clk);
        end
        chk("sw_done",  32'(done), 1);
        chk("sw_we_off", 32'(mem_we), 0);
        chk("sw_words", 32'(words_loaded), 1);
        chk("sw_busy_done", 32'(busy), 1);
        @(negedge clk);
        chk("sw_done_pulse", 32'(done), 0);
        chk("sw_idle", 32'(busy), 0);

        // back-pressure: valid held high across three words
        bp_w = '{32'hA1B2C3D4, 32'h0F1E2D3C, 32'h55AA66BB};
        do_start(7'h20);
        for (int i = 0; i < 3; i++) begin
            word_valid = 1'b1; word_data = bp_w[i]; word_last = (i == 2);
            wait_ready("bp_ready_timeout");
            rc[i] = cyc;
            @(negedge clk);
        end
        word_valid = 1'b0;
        chk("bp_gap01", 32'(rc[1] - rc[0]), 5);
        chk("bp_gap12", 32'(rc[2] - rc[1]), 5);
        wait_done("bp_done");
        chk("bp_words", 32'(words_loaded), 3);
        for (int i = 0; i < 12; i++)
            chk($sformatf("bp_byte%0d", i), 32'(mem[8'h20 + i]), 32'(bp_w[i/4][(i%4)*8 +: 8]));
        chk("bp_fetch_word2", fetch(8'h24), 32'h0F1E2D3C);
        @(negedge clk);

        // address wrap
        do_start(7'h7E);
        send_word(32'h11223344, 1'b1, "wr_ready_timeout");
        word_valid = 1'b0;
        wait_done("wr_done");
        chk("wr_7e", 32'(mem[7'h7E]), 32'h44);
        chk("wr_7f", 32'(mem[7'h7F]), 32'h33);
        chk("wr_00", 32'(mem[7'h00]), 32'h22);
        chk("wr_01", 32'(mem[7'h01]), 32'h11);
        chk("wr_flag", 32'(wrapped), 1);
        @(negedge clk);

        // start pulsed mid-WRITE is ignored
        do_start(7'h40);
        chk("ig_wrap_cleared", 32'(wrapped), 0);
        send_word(32'hCAFEF00D, 1'b0, "ig_ready_timeout");
        word_valid = 1'b0;
        @(negedge clk);               // beat 1 on the port
        start = 1'b1; base_addr = 7'h00;
        @(negedge clk);
        start = 1'b0;
        chk("ig_addr_beat2", 32'(mem_waddr), 32'h42);
        send_word(32'h13579BDF, 1'b1, "ig_ready2_timeout");
        word_valid = 1'b0;
        wait_done("ig_done");
        chk("ig_fetch0", fetch(8'h40), 32'hCAFEF00D);
        chk("ig_fetch1", fetch(8'h44), 32'h13579BDF);
        chk("ig_words", 32'(words_loaded), 2);
        @(negedge clk);

        // reset in the middle of a word, after beat 1
        do_start(7'h50);
        send_word(32'hDDCCBBAA, 1'b1, "rm_ready_timeout");
        word_valid = 1'b0;
        @(negedge clk);               // beat 1 on the port
        #2 rst = 1'b1;
        #1;
        chk("rm_we",    32'(mem_we), 0);
        chk("rm_busy",  32'(busy), 0);
        chk("rm_ready", 32'(word_ready), 0);
        chk("rm_addr",  32'(mem_waddr), 0);
        chk("rm_data",  32'(mem_wdata), 0);
        chk("rm_words", 32'(words_loaded), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rm_b50", 32'(mem[7'h50]), 32'hAA);
        chk("rm_b51", 32'(mem[7'h51]), 32'hBB);
        chk("rm_b52", 32'(mem[7'h52]), 32'hEE);
        chk("rm_b53", 32'(mem[7'h53]), 32'hEE);
        do_start(7'h60);
        send_word(32'h12345678, 1'b1, "rm2_ready_timeout");
        word_valid = 1'b0;
        wait_done("rm2_done");
        chk("rm2_fetch", fetch(8'h60), 32'h12345678);
        chk("rm2_words", 32'(words_loaded), 1);
        @(negedge clk);

        // words_loaded saturates at 255 over a 256-word session
        do_start(7'h00);
        for (int i = 0; i < 256; i++)
            send_word(32'(i), (i == 255), "sat_ready_timeout");
        word_valid = 1'b0;
        wait_done("sat_done");
        chk("sat_words", 32'(words_loaded), 255);
        chk("sat_wrapped", 32'(wrapped), 1);
        chk("sat_last_word", fetch(8'h7C), 32'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
